rv_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the RV32I pipeline, on a single clock.
- Holds the fetch PC and issues word-addressed reads to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions in a DEPTH-entry prefetch queue.
- Presents instructions to decode through a valid/ready handshake.
- Supports branch/jump redirect with full flush and a halt input that stops issuing.
- Sits between instruction memory and the IF/ID boundary; replaces the fixed single-register fetch stage.

---
 rtl/rv_pkg.sv | 41 ++++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/rv_fetch_queue.sv | 102 ++++++++++
 tb/tb_rv_fetch_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: widths, opcodes, funct3 codes.
// Also defines the fetch-queue entry layout {pc, ir}.
package rv_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 10;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] B_TYPE = 7'b1100011;
    localparam logic [6:0] L_TYPE = 7'b0000011;
    localparam logic [6:0] S_TYPE = 7'b0100011;
    localparam logic [6:0] J_TYPE = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Queue entry: pc in the upper bits, instruction below.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [XLEN_DEF-1:0]   ir;
    } fq_entry_t;

    function automatic int fq_entry_w(input int aw, input int xw);
        return aw + xw;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for the fetch queue; flush beats push/pop.
// Ports: clk, rst, flush_i, push_i, pop_i, data_i, head_o, count_o.
module fetch_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i && !rst;
    assign do_pop  = pop_i && !flush_i && (cnt_q != '0);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // The issue throttle upstream must never let a push hit a full queue.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(do_push && cnt_q == FULL_C));
    end

endmodule

// File: rtl/rv_fetch_queue.sv
// Fetch front end: PC, 1-cycle imem issue, prefetch queue, redirect/halt.
// Ports: imem_req/addr/rdata to memory; out_* valid/ready to decode.
module rv_fetch_queue
    import rv_pkg::*;
#(
    parameter int                XLEN     = XLEN_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       halted,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_ir,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_npc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = fq_entry_w(ADDR_W, XLEN);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ifl_pc_q, ifl_pc_d;
    logic              ifl_q, ifl_d;
    logic [EW-1:0]     last_q, last_d;
    logic [EW-1:0]     head;
    logic [EW-1:0]     hold;
    logic [CW-1:0]     count;
    logic [CW:0]       pending;
    logic              room;
    logic              push;
    logic              pop;

    // Queued entries plus the outstanding request must fit in DEPTH,
    // so a returning response always finds a free slot.
    assign pending = {1'b0, count} + (CW+1)'(ifl_q);
    assign room    = pending < (CW+1)'(DEPTH);

    assign imem_req  = !rst && !halted && !redirect_valid && room;
    assign imem_addr = pc_q;

    assign push = ifl_q && !redirect_valid;
    assign pop  = out_valid && out_ready && !redirect_valid;

    assign out_valid = (count != '0);
    assign occupancy = count;

    // When empty, keep presenting the last head seen.
    assign hold    = out_valid ? head : last_q;
    assign last_d  = hold;
    assign out_pc  = hold[EW-1 -: ADDR_W];
    assign out_ir  = hold[XLEN-1:0];
    assign out_npc = out_pc + ADDR_W'(1);

    always_comb begin
        pc_d     = pc_q;
        ifl_d    = imem_req;
        ifl_pc_d = ifl_pc_q;
        if (imem_req) begin
            pc_d     = pc_q + ADDR_W'(1);
            ifl_pc_d = pc_q;
        end
        if (redirect_valid) pc_d = redirect_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            ifl_q    <= 1'b0;
            ifl_pc_q <= '0;
            last_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            ifl_q    <= ifl_d;
            ifl_pc_q <= ifl_pc_d;
            last_q   <= last_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({ifl_pc_q, imem_rdata}),
        .head_o  (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Directed bench for rv_fetch_queue; imem word[a] = 0x100 + a.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_rv_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        halted;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [9:0]  out_pc;
    logic [9:0]  out_npc;
    logic [2:0]  occupancy;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    rv_fetch_queue #(
        .XLEN     (32),
        .ADDR_W   (10),
        .DEPTH    (4),
        .RESET_PC (10'h000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .halted         (halted),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ir         (out_ir),
        .out_pc         (out_pc),
        .out_npc        (out_npc),
        .occupancy      (occupancy)
    );

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'h100 + {22'b0, imem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        halted = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;

        // 1: reset state and streaming fetch
        tick(); #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_npc", out_npc, 1);
        tick(); rst = 1'b0; #1;
        chk("s_c0_req", imem_req, 1);
        chk("s_c0_addr", imem_addr, 0);
        chk("s_c0_valid", out_valid, 0);
        chk("s_c0_ir", out_ir, 0);
        chk("s_c0_pc", out_pc, 0);
        chk("s_c0_npc", out_npc, 1);
        tick(); #1;
        chk("s_c1_addr", imem_addr, 1);
        chk("s_c1_valid", out_valid, 0);
        tick(); #1;
        chk("s_c2_valid", out_valid, 1);
        chk("s_c2_ir", out_ir, 32'h100);
        chk("s_c2_addr", imem_addr, 2);
        tick(); #1;
        chk("s_c3_ir", out_ir, 32'h101);
        chk("s_c3_pc", out_pc, 1);
        chk("s_c3_npc", out_npc, 2);
        chk("s_c3_occ", occupancy, 1);
        tick(); #1;
        chk("s_c4_ir", out_ir, 32'h102);

        // 2: back-pressure fills the queue, then drains
        tick(); rst = 1'b1; out_ready = 1'b0; #1;
        chk("f_rst_req", imem_req, 0);
        tick(); rst = 1'b0; #1;
        chk("f_c0_addr", imem_addr, 0);
        tick(); #1;
        chk("f_c1_addr", imem_addr, 1);
        tick(); #1;
        chk("f_c2_addr", imem_addr, 2);
        tick(); #1;
        chk("f_c3_req", imem_req, 1);
        chk("f_c3_addr", imem_addr, 3);
        tick(); #1;
        chk("f_c4_req", imem_req, 0);
        chk("f_c4_occ", occupancy, 3);
        tick(); #1;
        chk("f_c5_req", imem_req, 0);
        chk("f_c5_occ", occupancy, 4);
        chk("f_c5_ir", out_ir, 32'h100);
        tick(); out_ready = 1'b1; #1;
        chk("f_c6_req", imem_req, 0);
        chk("f_c6_ir", out_ir, 32'h100);
        tick(); #1;
        chk("f_c7_req", imem_req, 1);
        chk("f_c7_addr", imem_addr, 4);
        chk("f_c7_ir", out_ir, 32'h101);
        tick(); #1;
        chk("f_c8_addr", imem_addr, 5);
        chk("f_c8_ir", out_ir, 32'h102);
        tick(); #1;
        chk("f_c9_ir", out_ir, 32'h103);
        tick(); #1;
        chk("f_c10_ir", out_ir, 32'h104);
        chk("f_c10_pc", out_pc, 4);
        chk("f_c10_npc", out_npc, 5);

        // 3: redirect with occupancy 3 and a request in flight
        tick(); rst = 1'b1; out_ready = 1'b0; #1;
        tick(); rst = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        tick(); #1;
        tick(); redirect_valid = 1'b1; redirect_pc = 10'h3F0; #1;
        chk("r_t0_occ", occupancy, 3);
        chk("r_t0_req", imem_req, 0);
        tick(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
        chk("r_t1_occ", occupancy, 0);
        chk("r_t1_valid", out_valid, 0);
        chk("r_t1_req", imem_req, 1);
        chk("r_t1_addr", imem_addr, 10'h3F0);
        tick(); #1;
        chk("r_t2_valid", out_valid, 0);
        chk("r_t2_addr", imem_addr, 10'h3F1);
        tick(); #1;
        chk("r_t3_valid", out_valid, 1);
        chk("r_t3_pc", out_pc, 10'h3F0);
        chk("r_t3_ir", out_ir, 32'h4F0);
        chk("r_t3_npc", out_npc, 10'h3F1);

        // 4: redirect to the top of the address space wraps
        tick(); redirect_valid = 1'b1; redirect_pc = 10'h3FF; #1;
        chk("w_t0_req", imem_req, 0);
        tick(); redirect_valid = 1'b0; #1;
        chk("w_t1_addr", imem_addr, 10'h3FF);
        chk("w_t1_occ", occupancy, 0);
        tick(); #1;
        chk("w_t2_addr", imem_addr, 10'h000);
        chk("w_t2_valid", out_valid, 0);
        tick(); #1;
        chk("w_t3_addr", imem_addr, 10'h001);
        chk("w_t3_pc", out_pc, 10'h3FF);
        chk("w_t3_ir", out_ir, 32'h4FF);
        chk("w_t3_npc", out_npc, 10'h000);
        tick(); #1;
        chk("w_t4_pc", out_pc, 10'h000);
        chk("w_t4_ir", out_ir, 32'h100);

        // 5: halt captures the in-flight response, redirect while halted
        tick(); halted = 1'b1; out_ready = 1'b0; #1;
        chk("h_c0_req", imem_req, 0);
        chk("h_c0_occ", occupancy, 1);
        chk("h_c0_pc", out_pc, 10'h001);
        tick(); #1;
        chk("h_c1_occ", occupancy, 2);
        chk("h_c1_req", imem_req, 0);
        chk("h_c1_ir", out_ir, 32'h101);
        tick(); redirect_valid = 1'b1; redirect_pc = 10'h155; #1;
        chk("h_c2_req", imem_req, 0);
        tick(); redirect_valid = 1'b0; #1;
        chk("h_c3_req", imem_req, 0);
        chk("h_c3_occ", occupancy, 0);
        tick(); halted = 1'b0; #1;
        chk("h_c4_req", imem_req, 1);
        chk("h_c4_addr", imem_addr, 10'h155);

        // 6: reset mid-stream with entries queued and one in flight
        tick(); #1;
        chk("x_c0_addr", imem_addr, 10'h156);
        tick(); #1;
        chk("x_c1_addr", imem_addr, 10'h157);
        chk("x_c1_occ", occupancy, 1);
        tick(); rst = 1'b1; #1;
        chk("x_c2_occ", occupancy, 2);
        chk("x_c2_req", imem_req, 0);
        tick(); rst = 1'b0; #1;
        chk("x_c3_req", imem_req, 1);
        chk("x_c3_addr", imem_addr, 0);
        chk("x_c3_valid", out_valid, 0);
        chk("x_c3_ir", out_ir, 0);
        chk("x_c3_pc", out_pc, 0);
        chk("x_c3_npc", out_npc, 1);
        chk("x_c3_occ", occupancy, 0);
        tick(); #1;
        chk("x_c4_valid", out_valid, 0);
        chk("x_c4_occ", occupancy, 0);
        tick(); #1;
        chk("x_c5_valid", out_valid, 1);
        chk("x_c5_ir", out_ir, 32'h100);
        chk("x_c5_pc", out_pc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
